// File: rtl/pc_fetch.sv
// Program counter plus one-stage instruction register for the picoMIPS core.
// Latency: I is captured into ir one edge after address is presented; stall holds all fetch state.
module pc_fetch #(
  parameter int Psize = 5,
  parameter int Isize = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_abs,
  input  logic             br_rel,
  input  logic [Psize-1:0] br_target,
  input  logic             halt_req,
  input  logic [Isize-1:0] I,
  output logic [Psize-1:0] address,
  output logic [Isize-1:0] ir,
  output logic [Psize-1:0] ir_pc,
  output logic             ir_valid,
  output logic             halted
);

  typedef enum logic {RUN, HALT} state_t;

  state_t state;

  localparam logic [Psize-1:0] ONE = {{(Psize-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      address  <= '0;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (stall) begin
            // decoder re-presents branch/halt requests once the stall clears
          end else if (ir_valid && halt_req) begin
            state    <= HALT;
            halted   <= 1'b1;
            ir_valid <= 1'b0;
          end else if (ir_valid && br_abs) begin
            address  <= br_target;
            ir       <= I;
            ir_pc    <= address;
            ir_valid <= 1'b0;
          end else if (ir_valid && br_rel) begin
            // Psize-bit wrap makes the sign extension of the offset implicit
            address  <= ir_pc + br_target;
            ir       <= I;
            ir_pc    <= address;
            ir_valid <= 1'b0;
          end else begin
            address  <= address + ONE;
            ir       <= I;
            ir_pc    <= address;
            ir_valid <= 1'b1;
          end
        end
        HALT: begin
          ir_valid <= 1'b0;
          halted   <= 1'b1;
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule
